// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register placed between core stages (IF/ID, ID/EX,
// EX/MEM, MEM/WB). Provides a valid/ready handshake, a synchronous flush that
// inserts a bubble carrying RESET_VAL, an optional two-entry skid buffer that
// breaks the combinational ready path, and a saturating stall-cycle counter.
module pipe_stage_reg #(
    parameter int unsigned       WIDTH     = 32,
    parameter logic [WIDTH-1:0]  RESET_VAL = WIDTH'(32'h0000_0013),
    parameter bit                SKID      = 1'b1,
    parameter int unsigned       CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             w_out_valid;
    logic             w_stall;
    logic [CNT_W-1:0] r_stall_cnt;

    generate
        if (SKID) begin : g_skid
            // EMPTY: nothing held; BUSY: main entry valid; FULL: main and skid valid.
            typedef enum logic [1:0] {
                ST_EMPTY = 2'd0,
                ST_BUSY  = 2'd1,
                ST_FULL  = 2'd2
            } state_t;

            state_t           r_state;
            logic [WIDTH-1:0] r_main;
            logic [WIDTH-1:0] r_skid;
            logic             r_in_ready;
            logic             r_out_valid;
            logic             w_push;
            logic             w_pop;

            assign w_push = in_valid & r_in_ready;
            assign w_pop  = r_out_valid & out_ready;

            // Skid FSM; in_ready and out_valid are flops updated with the state.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_state     <= ST_EMPTY;
                    r_main      <= RESET_VAL;
                    r_skid      <= RESET_VAL;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end else if (flush) begin
                    r_state     <= ST_EMPTY;
                    r_main      <= RESET_VAL;
                    r_skid      <= RESET_VAL;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end else begin
                    case (r_state)
                        ST_EMPTY: begin
                            if (w_push) begin
                                r_main      <= in_data;
                                r_out_valid <= 1'b1;
                                r_state     <= ST_BUSY;
                            end
                        end
                        ST_BUSY: begin
                            if (w_push && w_pop) begin
                                r_main <= in_data;
                            end else if (w_push) begin
                                r_skid     <= in_data;
                                r_in_ready <= 1'b0;
                                r_state    <= ST_FULL;
                            end else if (w_pop) begin
                                // Main data holds so out_data shows the last popped beat.
                                r_out_valid <= 1'b0;
                                r_state     <= ST_EMPTY;
                            end
                        end
                        ST_FULL: begin
                            if (w_pop) begin
                                r_main     <= r_skid;
                                r_in_ready <= 1'b1;
                                r_state    <= ST_BUSY;
                            end
                        end
                        default: begin
                            r_state     <= ST_EMPTY;
                            r_in_ready  <= 1'b1;
                            r_out_valid <= 1'b0;
                        end
                    endcase
                end
            end

            assign in_ready    = r_in_ready;
            assign w_out_valid = r_out_valid;
            assign out_data    = r_main;
        end else begin : g_flop
            logic             r_valid;
            logic [WIDTH-1:0] r_data;
            logic             w_in_ready;
            logic             w_push;
            logic             w_pop;

            // Single entry may refill in the same cycle it drains.
            assign w_in_ready = ~r_valid | out_ready;
            assign w_push     = in_valid & w_in_ready;
            assign w_pop      = r_valid & out_ready;

            // Single-entry holding register with bubble insertion on flush.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_valid <= 1'b0;
                    r_data  <= RESET_VAL;
                end else if (flush) begin
                    r_valid <= 1'b0;
                    r_data  <= RESET_VAL;
                end else if (w_push) begin
                    r_valid <= 1'b1;
                    r_data  <= in_data;
                end else if (w_pop) begin
                    r_valid <= 1'b0;
                end
            end

            assign in_ready    = w_in_ready;
            assign w_out_valid = r_valid;
            assign out_data    = r_data;
        end
    endgenerate

    assign w_stall = w_out_valid & ~out_ready;

    // Saturating count of back-pressured cycles; clear wins over increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (cnt_clr) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign out_valid = w_out_valid;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid instance (CNT_W=16) and a single-entry
// instance (CNT_W=4) share stimulus and are compared every cycle against a
// bounded-FIFO reference model.
module tb_pipe_stage_reg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic        cnt_clr;

    logic        s_in_ready, s_out_valid;
    logic [31:0] s_out_data;
    logic [15:0] s_stall;
    logic        f_in_ready, f_out_valid;
    logic [31:0] f_out_data;
    logic [3:0]  f_stall;

    int n_chk  = 0;
    int n_pass = 0;

    // Model state: index 0 = skid instance (capacity 2), 1 = single entry.
    logic [31:0] m_q    [2][2];
    int          m_n    [2];
    logic [31:0] m_last [2];
    int          m_stall[2];
    int          m_max  [2] = '{65535, 15};

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(32), .RESET_VAL(32'h13), .SKID(1'b1), .CNT_W(16)) u_skid (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .cnt_clr(cnt_clr), .stall_cnt(s_stall)
    );

    pipe_stage_reg #(.WIDTH(32), .RESET_VAL(32'h13), .SKID(1'b0), .CNT_W(4)) u_flop (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(f_in_ready), .in_data(in_data),
        .out_valid(f_out_valid), .out_ready(out_ready), .out_data(f_out_data),
        .cnt_clr(cnt_clr), .stall_cnt(f_stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, expv, $time);
    endtask

    function automatic logic exp_ready(input int m);
        if (m == 0) return (m_n[0] < 2);
        return (m_n[1] == 0) || out_ready;
    endfunction

    function automatic logic [31:0] exp_data(input int m);
        return (m_n[m] > 0) ? m_q[m][0] : m_last[m];
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_n[m]     = 0;
            m_last[m]  = NOP;
            m_stall[m] = 0;
        end
    endtask

    task automatic check_all();
        chk("skid_valid", 32'(s_out_valid), 32'(m_n[0] > 0));
        chk("skid_data",  s_out_data,       exp_data(0));
        chk("skid_ready", 32'(s_in_ready),  32'(exp_ready(0)));
        chk("skid_stall", 32'(s_stall),     32'(m_stall[0]));
        chk("flop_valid", 32'(f_out_valid), 32'(m_n[1] > 0));
        chk("flop_data",  f_out_data,       exp_data(1));
        chk("flop_ready", 32'(f_in_ready),  32'(exp_ready(1)));
        chk("flop_stall", 32'(f_stall),     32'(m_stall[1]));
    endtask

    // Advance both models across the coming rising edge.
    task automatic model_update();
        for (int m = 0; m < 2; m++) begin
            logic ov, push, pop;
            ov   = (m_n[m] > 0);
            push = in_valid && exp_ready(m);
            pop  = ov && out_ready;
            if (cnt_clr) m_stall[m] = 0;
            else if (ov && !out_ready && m_stall[m] < m_max[m]) m_stall[m]++;
            if (flush) begin
                m_n[m]    = 0;
                m_last[m] = NOP;
            end else begin
                if (pop) begin
                    m_last[m]  = m_q[m][0];
                    m_q[m][0]  = m_q[m][1];
                    m_n[m]--;
                end
                if (push) begin
                    m_q[m][m_n[m]] = in_data;
                    m_n[m]++;
                end
            end
        end
    endtask

    task automatic step(input logic v, input logic [31:0] d, input logic rdy,
                        input logic fl, input logic clr);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        flush     = fl;
        cnt_clr   = clr;
        #1;
        check_all();
        model_update();
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b0; cnt_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("rst_ready", 32'(s_in_ready), 32'd1);
        chk("rst_data",  s_out_data, NOP);

        // Streaming with downstream always ready
        step(1'b1, 32'h1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h2, 1'b1, 1'b0, 1'b0);
        chk("t1_first", s_out_data, 32'h1);
        step(1'b1, 32'h3, 1'b1, 1'b0, 1'b0);
        chk("t1_second", s_out_data, 32'h2);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("t1_third", s_out_data, 32'h3);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Fill skid under back-pressure, then drain in order
        step(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("t2_full_ready", 32'(s_in_ready), 32'd0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("t2_pop_a", s_out_data, 32'hA);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("t2_pop_b", s_out_data, 32'hB);
        chk("t2_ready_back", 32'(s_in_ready), 32'd1);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Flush a full stage together with an incoming beat
        step(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hC, 1'b0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("t3_valid", 32'(s_out_valid), 32'd0);
        chk("t3_data",  s_out_data, NOP);
        chk("t3_ready", 32'(s_in_ready), 32'd1);

        // Single-entry combinational ready
        step(1'b1, 32'h4, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("t4_stalled_ready", 32'(f_in_ready), 32'd0);
        step(1'b1, 32'h5, 1'b1, 1'b0, 1'b0);
        chk("t4_comb_ready", 32'(f_in_ready), 32'd1);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("t4_data", f_out_data, 32'h5);

        // 4-bit counter saturation and clear
        step(1'b1, 32'h9, 1'b0, 1'b0, 1'b0);
        repeat (20) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("t5_sat", 32'(f_stall), 32'd15);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("t5_clr", 32'(f_stall), 32'd0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("t5_inc", 32'(f_stall), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 3) != 0), $urandom,
                 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 31) == 0));
        end

        // Asynchronous reset between edges
        step(1'b1, 32'h20, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h21, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; cnt_clr = 1'b0; out_ready = 1'b1;
        #1;
        chk("t6_skid_valid", 32'(s_out_valid), 32'd0);
        chk("t6_skid_data",  s_out_data, NOP);
        chk("t6_skid_stall", 32'(s_stall), 32'd0);
        chk("t6_skid_ready", 32'(s_in_ready), 32'd1);
        chk("t6_flop_valid", 32'(f_out_valid), 32'd0);
        chk("t6_flop_stall", 32'(f_stall), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 32'h7, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("t6_skid_new", s_out_data, 32'h7);
        chk("t6_flop_new", f_out_data, 32'h7);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised elastic pipeline-stage register for the 5-stage RISC-V core. It replaces the plain enable flip-flop between stages with the following features:
- valid/ready handshake
- synchronous flush that inserts a bubble with a programmable NOP value
- optional 2-entry skid buffer that registers the upstream ready path
- saturating stall-cycle counter for performance analysis

Sits between IF/ID, ID/EX, EX/MEM and MEM/WB.

Parameters:
- WIDTH, 32, payload width in bits (≥1).
- RESET_VAL, 32'h0000_0013, value driven on out_data after reset and after flush (RV32I NOP for instruction-carrying stages). Width is WIDTH.
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
- CNT_W, 16, stall counter width.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- flush  input  1  synchronous bubble insertion, highest priority after reset.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  stage can accept a beat.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  downstream beat valid.
- out_ready  input  1  downstream accepts.
- out_data  output  WIDTH  downstream payload.
- cnt_clr  input  1  synchronous clear of stall_cnt.
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0.

Behaviour:
- Handshakes: push = in_valid & in_ready; pop = out_valid & out_ready. Beats leave in arrival order; none are dropped or duplicated except on flush.
- Reset (async assert, sync-safe release): out_valid=0, out_data=RESET_VAL, skid entry invalid, in_ready=1, stall_cnt=0.
- SKID=0, single entry:
  - in_ready = ~out_valid | out_ready (combinational).
  - On push: out_data<=in_data, out_valid<=1.
  - On pop without push: out_valid<=0; out_data holds its value.
  - Latency 1 cycle. Full throughput with back-to-back pop+push.
- SKID=1 states:
  - EMPTY: out_valid=0, in_ready=1.
  - BUSY: out_valid=1, skid invalid, in_ready=1.
  - FULL: out_valid=1, skid valid, in_ready=0.
- SKID=1 transitions:
  - EMPTY + push → BUSY; main<=in_data.
  - BUSY + push & pop → BUSY; main<=in_data.
  - BUSY + push & ~pop → FULL; skid<=in_data; in_ready<=0 (registered).
  - BUSY + pop & ~push → EMPTY; main data holds.
  - FULL + pop → BUSY; main<=skid; in_ready<=1.
  - FULL + ~pop → FULL; no data change.
- SKID=1 timing: in_ready is a flop output with no combinational path from out_ready. Latency 1 cycle; full throughput whenever out_ready stays 1.
- Flush (both modes): next cycle out_valid=0, skid invalid, out_data=RESET_VAL, in_ready=1, state EMPTY.
  - A push in the flush cycle is accepted upstream and discarded.
  - A pop in the flush cycle completes normally; downstream sees that beat.
- Stall counter: +1 each cycle with out_valid & ~out_ready. Saturates at 2^CNT_W−1 with no wrap.
  - cnt_clr has priority over increment; cleared value is 0 next cycle.
  - Flush does not clear stall_cnt.
- Reset mid-operation: all beats are lost immediately and outputs take their reset values asynchronously.
- out_data when out_valid=0 is RESET_VAL after reset/flush, otherwise the last popped value. Downstream must qualify data with out_valid.

Test Plan:
1. Reset then stream 0x1,0x2,0x3 with out_ready=1 (SKID=1) → out_data 0x1,0x2,0x3 on consecutive cycles, each one cycle after its push; in_ready stays 1; stall_cnt=0.
2. Push 0xA, 0xB with out_ready=0 → state FULL and in_ready=0 in the cycle after 0xB. Raise out_ready → pops 0xA then 0xB; in_ready=1 one cycle after the first pop; stall_cnt equals the number of stalled cycles.
3. FULL holding 0xA/0xB, assert flush together with in_valid=1, in_data=0xC → next cycle out_valid=0, out_data=32'h13, in_ready=1; 0xA, 0xB and 0xC never appear.
4. SKID=0, out_valid=1 with out_ready=0 → in_ready=0 combinationally. Same cycle set out_ready=1 with in_valid=1, data 0x5 → in_ready=1; 0x5 appears next cycle.
5. CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles → stall_cnt saturates at 15. Pulse cnt_clr → 0 next cycle, then increments from 1.
6. Assert reset asynchronously mid-stream (between clock edges) → out_valid=0, out_data=RESET_VAL, stall_cnt=0 before the next edge. After release, accepts a new beat 0x7 normally.
